// File: rtl/fp_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_seq
//  Description : Sequential IEEE-754 binary multiplier. Radix-2 shift-add
//                mantissa datapath (one bit per cycle), five rounding modes,
//                flush-to-zero on inputs and outputs, valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+FRC_W:0] fp_X,
    input  logic [EXP_W+FRC_W:0] fp_Y,
    input  logic [2:0]           r_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+FRC_W:0] fp_Z,
    output logic                 ovrf,
    output logic                 udrf,
    output logic                 nv
);

    localparam int c_man_w = FRC_W + 1;
    localparam int c_prd_w = 2 * c_man_w;
    localparam int c_ez_w  = EXP_W + 2;
    localparam int c_cnt_w = $clog2(c_man_w + 1);

    localparam logic [c_ez_w-1:0]      c_bias   = c_ez_w'((1 << (EXP_W - 1)) - 1);
    localparam logic [c_ez_w-1:0]      c_ez_inf = c_ez_w'((1 << EXP_W) - 1);
    localparam logic [EXP_W+FRC_W:0]   c_qnan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};

    localparam logic [2:0] c_rtz = 3'b001;
    localparam logic [2:0] c_rdn = 3'b010;
    localparam logic [2:0] c_rup = 3'b011;
    localparam logic [2:0] c_rmm = 3'b100;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mult = 2'd1;
    localparam logic [1:0] c_st_norm = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_prd_w-1:0] r_acc;
    logic [c_prd_w-1:0] r_mcand;
    logic [c_man_w-1:0] r_mplier;
    logic [EXP_W-1:0]   r_ex;
    logic [EXP_W-1:0]   r_ey;
    logic               r_sz;
    logic [2:0]         r_rmode;

    // operand field split and classification at the input port
    logic [EXP_W-1:0] w_ex, w_ey;
    logic [FRC_W-1:0] w_fx, w_fy;
    logic             w_sx, w_sy;
    logic             w_x_zero, w_y_zero, w_x_emax, w_y_emax;
    logic             w_x_nan, w_y_nan, w_x_snan, w_y_snan, w_x_inf, w_y_inf;
    logic             w_special;

    assign w_sx      = fp_X[EXP_W+FRC_W];
    assign w_sy      = fp_Y[EXP_W+FRC_W];
    assign w_ex      = fp_X[EXP_W+FRC_W-1:FRC_W];
    assign w_ey      = fp_Y[EXP_W+FRC_W-1:FRC_W];
    assign w_fx      = fp_X[FRC_W-1:0];
    assign w_fy      = fp_Y[FRC_W-1:0];
    assign w_x_zero  = (w_ex == '0);
    assign w_y_zero  = (w_ey == '0);
    assign w_x_emax  = &w_ex;
    assign w_y_emax  = &w_ey;
    assign w_x_nan   = w_x_emax && (w_fx != '0);
    assign w_y_nan   = w_y_emax && (w_fy != '0);
    assign w_x_snan  = w_x_nan && !w_fx[FRC_W-1];
    assign w_y_snan  = w_y_nan && !w_fy[FRC_W-1];
    assign w_x_inf   = w_x_emax && (w_fx == '0);
    assign w_y_inf   = w_y_emax && (w_fy == '0);
    assign w_special = w_x_emax | w_y_emax | w_x_zero | w_y_zero;

    logic [EXP_W+FRC_W:0] w_sp_z;
    logic                 w_sp_nv;

    // result for special operands, ordered NaN > Inf*0 > Inf > zero
    always_comb begin
        w_sp_z  = {w_sx ^ w_sy, {(EXP_W+FRC_W){1'b0}}};
        w_sp_nv = 1'b0;
        if (w_x_nan || w_y_nan) begin
            w_sp_z  = c_qnan;
            w_sp_nv = w_x_snan | w_y_snan;
        end else if ((w_x_inf && w_y_zero) || (w_x_zero && w_y_inf)) begin
            w_sp_z  = c_qnan;
            w_sp_nv = 1'b1;
        end else if (w_x_inf || w_y_inf) begin
            w_sp_z = {w_sx ^ w_sy, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        end
    end

    // normalise / round datapath fed by the finished product
    logic                 w_top, w_g, w_s, w_l, w_inc, w_unf, w_ovf;
    logic [c_prd_w-1:0]   w_pn;
    logic [c_man_w-1:0]   w_mant;
    logic [c_man_w:0]     w_mr;
    logic [FRC_W-1:0]     w_frac;
    logic [c_ez_w-1:0]    w_ez0, w_ez1, w_ez2;
    logic [EXP_W+FRC_W:0] w_nz, w_inf, w_max;

    assign w_ez0  = {2'b00, r_ex} + {2'b00, r_ey} - c_bias;
    assign w_top  = r_acc[c_prd_w-1];
    assign w_ez1  = w_ez0 + {{(c_ez_w-1){1'b0}}, w_top};
    assign w_pn   = w_top ? r_acc : (r_acc << 1);
    assign w_mant = w_pn[c_prd_w-1 -: c_man_w];
    assign w_g    = w_pn[c_man_w-1];
    assign w_s    = |w_pn[c_man_w-2:0];
    assign w_l    = w_mant[0];

    // rounding increment selected by the captured mode
    always_comb begin
        w_inc = w_g & (w_s | w_l);
        case (r_rmode)
            c_rtz:   w_inc = 1'b0;
            c_rdn:   w_inc = (w_g | w_s) & r_sz;
            c_rup:   w_inc = (w_g | w_s) & ~r_sz;
            c_rmm:   w_inc = w_g;
            default: w_inc = w_g & (w_s | w_l);
        endcase
    end

    assign w_mr   = {1'b0, w_mant} + {{c_man_w{1'b0}}, w_inc};
    // a carry out of rounding leaves 1.000..0 one position higher
    assign w_frac = w_mr[c_man_w] ? w_mr[FRC_W:1] : w_mr[FRC_W-1:0];
    assign w_ez2  = w_ez1 + {{(c_ez_w-1){1'b0}}, w_mr[c_man_w]};
    // underflow is judged before rounding; ez is two's complement
    assign w_unf  = w_ez1[c_ez_w-1] || (w_ez1 == '0);
    assign w_ovf  = !w_unf && (w_ez2 >= c_ez_inf);
    assign w_inf  = {r_sz, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
    assign w_max  = {r_sz, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};

    // pack the normal-path result, saturating per rounding direction
    always_comb begin
        w_nz = {r_sz, w_ez2[EXP_W-1:0], w_frac};
        if (w_unf) begin
            w_nz = {r_sz, {(EXP_W+FRC_W){1'b0}}};
        end else if (w_ovf) begin
            case (r_rmode)
                c_rtz:   w_nz = w_max;
                c_rdn:   w_nz = r_sz ? w_inf : w_max;
                c_rup:   w_nz = r_sz ? w_max : w_inf;
                default: w_nz = w_inf;
            endcase
        end
    end

    assign in_ready = (r_state == c_st_idle);

    // control FSM, shift-add datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_ex      <= '0;
            r_ey      <= '0;
            r_sz      <= 1'b0;
            r_rmode   <= 3'b000;
            out_valid <= 1'b0;
            fp_Z      <= '0;
            ovrf      <= 1'b0;
            udrf      <= 1'b0;
            nv        <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_ex    <= w_ex;
                        r_ey    <= w_ey;
                        r_sz    <= w_sx ^ w_sy;
                        r_rmode <= r_mode;
                        if (w_special) begin
                            r_state   <= c_st_done;
                            out_valid <= 1'b1;
                            fp_Z      <= w_sp_z;
                            nv        <= w_sp_nv;
                            ovrf      <= 1'b0;
                            udrf      <= 1'b0;
                        end else begin
                            r_state  <= c_st_mult;
                            r_cnt    <= c_cnt_w'(c_man_w);
                            r_acc    <= '0;
                            r_mcand  <= {{c_man_w{1'b0}}, 1'b1, w_fx};
                            r_mplier <= {1'b1, w_fy};
                        end
                    end
                end
                c_st_mult: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= c_st_norm;
                    end
                end
                c_st_norm: begin
                    r_state   <= c_st_done;
                    out_valid <= 1'b1;
                    fp_Z      <= w_nz;
                    ovrf      <= w_ovf;
                    udrf      <= w_unf;
                    nv        <= 1'b0;
                end
                c_st_done: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
